// File: rtl/sfifo_rd_stream.sv
// Pop stage for sfifo: issues credit-limited pops, absorbs the FIFO read latency in a
// small circular skid buffer and presents a valid/ready stream at one beat per cycle.
module sfifo_rd_stream #(
  parameter int unsigned FIFO_W   = 32,
  parameter int unsigned FIFO_DLY = 0,
  parameter int unsigned BUF_D    = FIFO_DLY + 2,
  parameter int unsigned BUF_A    = $clog2(BUF_D + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_re,
  input  logic [FIFO_W-1:0] fifo_rd,
  input  logic              fifo_empt,
  input  logic              fifo_udf,
  output logic              fifo_fsh,
  input  logic              flush,
  output logic              m_valid,
  output logic [FIFO_W-1:0] m_data,
  input  logic              m_ready,
  output logic [BUF_A-1:0]  buf_cnt,
  output logic              err_udf
);

  localparam int unsigned PtrW = (BUF_D > 1) ? $clog2(BUF_D) : 1;

  logic [FIFO_W-1:0] mem_q [BUF_D];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [BUF_A-1:0]  cnt_q;
  logic [BUF_A-1:0]  infl;
  logic              land;
  logic              xfer;
  logic              err_q;

  function automatic logic [PtrW-1:0] nxt_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(BUF_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit covers both buffered words and pops whose data is still in the FIFO pipe.
  assign fifo_re  = !rst && !flush && !fifo_empt && ((cnt_q + infl) < BUF_A'(BUF_D));
  assign fifo_fsh = flush && !rst;
  assign m_valid  = (cnt_q != '0) && !flush;
  assign m_data   = mem_q[rd_ptr_q];
  assign xfer     = m_valid && m_ready;
  assign buf_cnt  = cnt_q;
  assign err_udf  = err_q;

  if (FIFO_DLY == 0) begin : g_nodly
    assign land = fifo_re;
    assign infl = '0;
  end else begin : g_dly
    logic [FIFO_DLY-1:0] trk_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        trk_q <= '0;
      end else if (flush) begin
        trk_q <= '0;
      end else begin
        trk_q <= (trk_q << 1) | FIFO_DLY'(fifo_re);
      end
    end

    assign land = trk_q[FIFO_DLY-1];
    assign infl = BUF_A'($countones(trk_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < BUF_D; i++) mem_q[i] <= '0;
    end else if (flush) begin
      // Landing data of pops issued before the flush is dropped here.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (land) begin
        mem_q[wr_ptr_q] <= fifo_rd;
        wr_ptr_q        <= nxt_ptr(wr_ptr_q);
      end
      if (xfer) rd_ptr_q <= nxt_ptr(rd_ptr_q);
      cnt_q <= cnt_q + BUF_A'(land) - BUF_A'(xfer);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (fifo_udf) begin
      err_q <= 1'b1;
    end
  end

  buf_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= BUF_A'(BUF_D));

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Bench for sfifo_rd_stream: three instances (read latency 0, 2, 3) share the stimulus; each
// has its own sfifo model and an in-order scoreboard of the word stream.
module tb_sfifo_rd_stream;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst, flush, m_ready, fifo_udf;
  logic [31:0] fifo_rd [NI];
  logic fifo_empt [NI];
  wire fifo_re [NI];
  wire fifo_fsh [NI];
  wire m_valid [NI];
  wire err_udf [NI];
  wire [31:0] m_data [NI];
  wire [1:0] cnt0;
  wire [2:0] cnt2, cnt3;

  always #5 clk = ~clk;

  sfifo_rd_stream #(.FIFO_W(32), .FIFO_DLY(0)) u_d0 (
    .clk(clk), .rst(rst), .fifo_re(fifo_re[0]), .fifo_rd(fifo_rd[0]),
    .fifo_empt(fifo_empt[0]), .fifo_udf(fifo_udf), .fifo_fsh(fifo_fsh[0]), .flush(flush),
    .m_valid(m_valid[0]), .m_data(m_data[0]), .m_ready(m_ready), .buf_cnt(cnt0),
    .err_udf(err_udf[0]));
  sfifo_rd_stream #(.FIFO_W(32), .FIFO_DLY(2)) u_d2 (
    .clk(clk), .rst(rst), .fifo_re(fifo_re[1]), .fifo_rd(fifo_rd[1]),
    .fifo_empt(fifo_empt[1]), .fifo_udf(fifo_udf), .fifo_fsh(fifo_fsh[1]), .flush(flush),
    .m_valid(m_valid[1]), .m_data(m_data[1]), .m_ready(m_ready), .buf_cnt(cnt2),
    .err_udf(err_udf[1]));
  sfifo_rd_stream #(.FIFO_W(32), .FIFO_DLY(3)) u_d3 (
    .clk(clk), .rst(rst), .fifo_re(fifo_re[2]), .fifo_rd(fifo_rd[2]),
    .fifo_empt(fifo_empt[2]), .fifo_udf(fifo_udf), .fifo_fsh(fifo_fsh[2]), .flush(flush),
    .m_valid(m_valid[2]), .m_data(m_data[2]), .m_ready(m_ready), .buf_cnt(cnt3),
    .err_udf(err_udf[2]));

  // Reference state: word stream, per-instance pop/expect indices and sfifo read pipe.
  logic [31:0] src [512];
  int avail;
  int pop_idx [NI], exp_idx [NI], cnt_m [NI], xfer_obs [NI];
  int pidx [NI][4];
  bit praw [NI][4], plive [NI][4], err_m [NI];
  int checks, failures, cyc;

  function automatic int dly(int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  function automatic int get_cnt(int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dly=%0d cyc=%0d got=0x%0h want=0x%0h", name, dly(k), cyc, act, exp);
    end
  endtask

  task automatic load(logic [31:0] base, int n);
    for (int i = 0; i < n; i++) begin
      src[avail] = base + 32'(i);
      avail++;
    end
  endtask

  task automatic drive();
    logic [31:0] junk;
    junk = 32'hBAD0_0000 | 32'(cyc);
    for (int k = 0; k < NI; k++) begin
      int d;
      d = dly(k);
      fifo_empt[k] = !(pop_idx[k] < avail);
      if (d == 0) fifo_rd[k] = (pop_idx[k] < avail) ? src[pop_idx[k]] : junk;
      else fifo_rd[k] = praw[k][d-1] ? src[pidx[k][d-1]] : junk;
    end
  endtask

  task automatic eval();
    for (int k = 0; k < NI; k++) begin
      int d, infl;
      bit exp_re, exp_v, xfer, land;
      d = dly(k);
      infl = 0;
      for (int j = 0; j < d; j++) infl += int'(plive[k][j]);
      exp_re = !rst && !flush && (pop_idx[k] < avail) && (cnt_m[k] + infl < d + 2);
      exp_v  = !rst && !flush && (cnt_m[k] != 0);
      chk("fifo_re", k, 32'(fifo_re[k]), 32'(exp_re));
      chk("m_valid", k, 32'(m_valid[k]), 32'(exp_v));
      chk("buf_cnt", k, 32'(get_cnt(k)), 32'(cnt_m[k]));
      chk("fifo_fsh", k, 32'(fifo_fsh[k]), 32'(flush && !rst));
      chk("err_udf", k, 32'(err_udf[k]), 32'(err_m[k]));
      xfer = exp_v && m_ready;
      if (xfer) chk("m_data", k, m_data[k], src[exp_idx[k]]);
      if (m_valid[k] && m_ready) xfer_obs[k]++;
      if (d == 0) land = exp_re;
      else land = plive[k][d-1];
      if (rst || flush) cnt_m[k] = 0;
      else cnt_m[k] = cnt_m[k] + int'(land) - int'(xfer);
      if (xfer) exp_idx[k]++;
      for (int j = 3; j > 0; j--) begin
        pidx[k][j] = pidx[k][j-1];
        praw[k][j] = praw[k][j-1];
        plive[k][j] = plive[k][j-1];
      end
      pidx[k][0] = pop_idx[k];
      praw[k][0] = exp_re;
      plive[k][0] = exp_re;
      if (exp_re) pop_idx[k]++;
      if (rst || flush) begin
        for (int j = 0; j < 4; j++) plive[k][j] = 1'b0;
        exp_idx[k] = pop_idx[k];
      end
      if (rst) err_m[k] = 1'b0;
      else if (fifo_udf) err_m[k] = 1'b1;
    end
  endtask

  task automatic step(bit rs, bit rdy, bit fl, bit udf);
    @(negedge clk);
    rst = rs;
    m_ready = rdy;
    flush = fl;
    fifo_udf = udf;
    drive();
    #1;
    eval();
    cyc++;
  endtask

  typedef struct {
    bit          rdy;
    bit          re;
    bit          v;
    logic [31:0] data;
    int          cnt;
  } vec_t;

  vec_t tv [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base [NI];
    int n, found;
    // Latency 2, 8 words preloaded, consumer always ready.
    tv[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 0};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 32'h00, 0};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 32'h00, 0};
    tv[3]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 32'h11, 1};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 32'h12, 1};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 32'h13, 1};
    tv[7]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 32'h15, 1};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 32'h16, 1};
    tv[10] = '{1'b1, 1'b0, 1'b1, 32'h17, 1};
    tv[11] = '{1'b1, 1'b0, 1'b0, 32'h00, 0};

    checks = 0; failures = 0; cyc = 0; avail = 0;
    for (int k = 0; k < NI; k++) begin
      pop_idx[k] = 0; exp_idx[k] = 0; cnt_m[k] = 0; xfer_obs[k] = 0; err_m[k] = 1'b0;
      for (int j = 0; j < 4; j++) begin
        pidx[k][j] = 0; praw[k][j] = 1'b0; plive[k][j] = 1'b0;
      end
    end
    rst = 1'b1; m_ready = 1'b0; flush = 1'b0; fifo_udf = 1'b0;
    drive();

    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    for (int k = 0; k < NI; k++) chk("rst_m_data", k, m_data[k], 32'h0);
    step(0, 0, 0, 0);

    // Full-throughput stream
    load(32'h10, 8);
    for (int i = 0; i < 12; i++) begin
      step(0, tv[i].rdy, 0, 0);
      chk("t1_re", 1, 32'(fifo_re[1]), 32'(tv[i].re));
      chk("t1_valid", 1, 32'(m_valid[1]), 32'(tv[i].v));
      chk("t1_cnt", 1, 32'(cnt2), 32'(tv[i].cnt));
      if (tv[i].v) chk("t1_data", 1, m_data[1], tv[i].data);
    end

    // Backpressure: exactly BUF_D pops, head word held, then full drain
    load(32'h20, 8);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      if (fifo_re[1]) n++;
      if (i >= 3) chk("t2_hold_data", 1, m_data[1], 32'h20);
    end
    chk("t2_pops", 1, 32'(n), 32'd4);
    chk("t2_cnt", 1, 32'(cnt2), 32'd4);
    base[1] = xfer_obs[1];
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    chk("t2_delivered", 1, 32'(xfer_obs[1] - base[1]), 32'd8);

    // Random consumer and random FIFO fill, 100 words
    for (int k = 0; k < NI; k++) base[k] = xfer_obs[k];
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (n < 100 && $urandom_range(0, 2) != 0) begin
        load($urandom, 1);
        n++;
      end
      step(0, 1'($urandom_range(0, 1)), 0, 0);
      chk("t3_d0_cnt_le2", 0, 32'(cnt0 <= 2'd2), 32'd1);
    end
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    chk("t3_words_loaded", 0, 32'(n), 32'd100);
    for (int k = 0; k < NI; k++) chk("t3_delivered", k, 32'(xfer_obs[k] - base[k]), 32'd100);

    // Flush with two pops in flight and two words buffered (latency 3)
    load(32'h40, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("t4_cnt_before", 2, 32'(cnt3), 32'd2);
    chk("t4_fsh", 2, 32'(fifo_fsh[2]), 32'd1);
    chk("t4_valid", 2, 32'(m_valid[2]), 32'd0);
    chk("t4_re", 2, 32'(fifo_re[2]), 32'd0);
    step(0, 1, 0, 0);
    chk("t4_cnt_after", 2, 32'(cnt3), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0);
      if (m_valid[2]) n++;
    end
    chk("t4_no_stale", 2, 32'(n), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0);
      chk("t4_fsh_held", 1, 32'(fifo_fsh[1]), 32'd1);
    end

    // Underflow flag is sticky
    step(0, 1, 0, 0);
    for (int k = 0; k < NI; k++) chk("t5_err_pre", k, 32'(err_udf[k]), 32'd0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      for (int k = 0; k < NI; k++) chk("t5_err_sticky", k, 32'(err_udf[k]), 32'd1);
    end

    // Asynchronous reset mid-stream with three words buffered
    load(32'h60, 8);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      if (cnt2 == 3'd3) break;
    end
    chk("t6_cnt3", 1, 32'(cnt2), 32'd3);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("t6_rst_valid", k, 32'(m_valid[k]), 32'd0);
      chk("t6_rst_re", k, 32'(fifo_re[k]), 32'd0);
      chk("t6_rst_cnt", k, 32'(get_cnt(k)), 32'd0);
      chk("t6_rst_err", k, 32'(err_udf[k]), 32'd0);
      cnt_m[k] = 0; err_m[k] = 1'b0;
      pop_idx[k] = avail; exp_idx[k] = avail;
      for (int j = 0; j < 4; j++) plive[k][j] = 1'b0;
    end
    step(1, 0, 0, 0);
    load(32'hA0, 4);
    found = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0);
      if (m_valid[1]) begin
        chk("t6_first_data", 1, m_data[1], 32'hA0);
        found = 1;
        break;
      end
    end
    chk("t6_first_found", 1, 32'(found), 32'd1);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
